// File: rtl/mips_core_pkg.sv
// Types and constants shared by register_renaming and instr_issue_queue.
package mips_core_pkg;
  localparam int IQ_DEPTH      = 16;
  localparam int PREG_W        = 6;
  localparam int NUM_PHYS_REGS = 1 << PREG_W;
  localparam int TAG_W         = 32;

  typedef struct packed {
    logic [TAG_W-1:0]  count;
    logic [31:0]       pc;
    logic [5:0]        alu_op;
    logic [PREG_W-1:0] rd_phys;
    logic [PREG_W-1:0] rs_phys;
    logic [PREG_W-1:0] rt_phys;
    logic              uses_rs;
    logic              uses_rt;
    logic              writes_rd;
    logic              ready;
  } Instr_Queue_Entry_t;

  // Wrap-safe age compares on the modular instruction counter.
  function automatic logic tag_older(input logic [TAG_W-1:0] a, input logic [TAG_W-1:0] b);
    logic [TAG_W-1:0] d;
    d = a - b;
    return d[TAG_W-1];
  endfunction

  function automatic logic tag_younger(input logic [TAG_W-1:0] a, input logic [TAG_W-1:0] b);
    logic [TAG_W-1:0] d;
    d = a - b;
    return !d[TAG_W-1] && (d != '0);
  endfunction
endpackage

// File: rtl/iq_age_select.sv
// Combinational oldest-ready picker: one-hot grant over the request vector.
module iq_age_select
  import mips_core_pkg::*;
#(
  parameter int N = 16
) (
  input  logic [N-1:0]            req,
  input  logic [N-1:0][TAG_W-1:0] tags,
  output logic [N-1:0]            grant,
  output logic                    found
);
  logic [TAG_W-1:0] best;

  // Linear scan; equal tags fall to the lower index.
  always_comb begin
    grant = '0;
    found = 1'b0;
    best  = '0;
    for (int i = 0; i < N; i++) begin
      if (req[i] && (!found || tag_older(tags[i], best))) begin
        grant    = '0;
        grant[i] = 1'b1;
        best     = tags[i];
        found    = 1'b1;
      end
    end
  end
endmodule

// File: rtl/instr_issue_queue.sv
// Issue queue: holds renamed instructions until sources are ready, issues oldest-ready.
module instr_issue_queue
  import mips_core_pkg::*;
#(
  parameter int DEPTH         = IQ_DEPTH,
  parameter int NUM_PHYS_REGS = 1 << PREG_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  Instr_Queue_Entry_t         in_entry,
  output logic                       in_ready,
  input  logic [NUM_PHYS_REGS-1:0]   busy_bits,
  input  logic                       wb_valid,
  input  logic [PREG_W-1:0]          wb_preg,
  input  logic                       flush,
  input  logic [TAG_W-1:0]           flush_tag,
  output logic                       issue_valid,
  output Instr_Queue_Entry_t         issue_entry,
  input  logic                       issue_ready,
  output logic [$clog2(DEPTH):0]     occupancy
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int OCC_W = IDX_W + 1;

  Instr_Queue_Entry_t             ent [DEPTH];
  logic [DEPTH-1:0]               valid, rs_rdy, rt_rdy;
  logic [DEPTH-1:0]               req, grant;
  logic [DEPTH-1:0][TAG_W-1:0]    tags;
  logic                           found;
  logic [IDX_W-1:0]               win_idx, ins_idx;
  logic                           do_ins, issue_load, ins_rs_rdy, ins_rt_rdy;

  function automatic logic src_ok(input logic use_src, input logic [PREG_W-1:0] p);
    return !use_src || !busy_bits[p] || (wb_valid && wb_preg == p);
  endfunction

  always_comb begin
    occupancy = '0;
    ins_idx   = '0;
    win_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occupancy = occupancy + OCC_W'(valid[i]);
      req[i]    = valid[i] && rs_rdy[i] && rt_rdy[i];
      tags[i]   = ent[i].count;
      if (grant[i]) win_idx = IDX_W'(i);
    end
    for (int i = DEPTH - 1; i >= 0; i--)
      if (!valid[i]) ins_idx = IDX_W'(i);
  end

  iq_age_select #(.N(DEPTH)) u_sel (
    .req   (req),
    .tags  (tags),
    .grant (grant),
    .found (found)
  );

  assign in_ready   = (occupancy < OCC_W'(DEPTH));
  assign do_ins     = in_valid && in_ready && !flush;
  assign issue_load = !issue_valid || issue_ready;
  assign ins_rs_rdy = src_ok(in_entry.uses_rs, in_entry.rs_phys);
  assign ins_rt_rdy = src_ok(in_entry.uses_rt, in_entry.rt_phys);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid       <= '0;
      rs_rdy      <= '0;
      rt_rdy      <= '0;
      issue_valid <= 1'b0;
      issue_entry <= '0;
    end else begin
      // Wakeup applies to surviving entries even on a flush edge.
      for (int i = 0; i < DEPTH; i++) begin
        if (wb_valid && valid[i] && ent[i].rs_phys == wb_preg) rs_rdy[i] <= 1'b1;
        if (wb_valid && valid[i] && ent[i].rt_phys == wb_preg) rt_rdy[i] <= 1'b1;
      end
      if (flush) begin
        for (int i = 0; i < DEPTH; i++)
          if (valid[i] && tag_younger(ent[i].count, flush_tag)) valid[i] <= 1'b0;
        // No select this edge: an accepted or squashed issue slot simply empties.
        if (issue_valid && (issue_ready || tag_younger(issue_entry.count, flush_tag)))
          issue_valid <= 1'b0;
      end else begin
        if (issue_load) begin
          issue_valid <= found;
          if (found) begin
            issue_entry      <= ent[win_idx];
            valid[win_idx]   <= 1'b0;
          end
        end
        if (do_ins) begin
          valid[ins_idx]  <= 1'b1;
          ent[ins_idx]    <= in_entry;
          rs_rdy[ins_idx] <= ins_rs_rdy;
          rt_rdy[ins_idx] <= ins_rt_rdy;
        end
      end
    end
  end
endmodule

// File: tb/tb_instr_issue_queue.sv
// Directed bench for instr_issue_queue: issue, wakeup, age order, full, flush.
module tb_instr_issue_queue;
  import mips_core_pkg::*;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     in_valid;
  Instr_Queue_Entry_t       in_entry;
  logic                     in_ready;
  logic [NUM_PHYS_REGS-1:0] busy_bits;
  logic                     wb_valid;
  logic [PREG_W-1:0]        wb_preg;
  logic                     flush;
  logic [TAG_W-1:0]         flush_tag;
  logic                     issue_valid;
  Instr_Queue_Entry_t       issue_entry;
  logic                     issue_ready;
  logic [4:0]               occupancy;

  int checks = 0;
  int errors = 0;

  instr_issue_queue dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_entry(in_entry), .in_ready(in_ready),
    .busy_bits(busy_bits), .wb_valid(wb_valid), .wb_preg(wb_preg), .flush(flush),
    .flush_tag(flush_tag), .issue_valid(issue_valid), .issue_entry(issue_entry),
    .issue_ready(issue_ready), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic Instr_Queue_Entry_t mk(input logic [TAG_W-1:0] tag,
                                            input logic [PREG_W-1:0] rs,
                                            input logic [PREG_W-1:0] rt);
    Instr_Queue_Entry_t e;
    e = '0;
    e.count   = tag;
    e.pc      = tag << 2;
    e.rd_phys = 6'd1;
    e.rs_phys = rs;
    e.rt_phys = rt;
    e.uses_rs = 1'b1;
    e.uses_rt = 1'b1;
    e.writes_rd = 1'b1;
    return e;
  endfunction

  task automatic ins(input Instr_Queue_Entry_t e);
    in_valid = 1'b1;
    in_entry = e;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wb(input logic [PREG_W-1:0] p);
    wb_valid = 1'b1;
    wb_preg  = p;
    tick();
    wb_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_entry = '0; busy_bits = '0; wb_valid = 1'b0;
    wb_preg = '0; flush = 1'b0; flush_tag = '0; issue_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk("rst_issue_valid", 64'(issue_valid), 64'd0);
    chk("rst_issue_entry", 64'(issue_entry.count), 64'd0);
    chk("rst_occupancy",   64'(occupancy), 64'd0);
    chk("rst_in_ready",    64'(in_ready), 64'd1);

    // Basic issue
    ins(mk(32'd0, 6'd5, 6'd6));
    chk("basic_occ_after_ins", 64'(occupancy), 64'd1);
    chk("basic_not_yet",       64'(issue_valid), 64'd0);
    tick();
    chk("basic_issue_valid", 64'(issue_valid), 64'd1);
    chk("basic_issue_count", 64'(issue_entry.count), 64'd0);
    chk("basic_issue_rs",    64'(issue_entry.rs_phys), 64'd5);
    chk("basic_occ_zero",    64'(occupancy), 64'd0);
    tick();
    chk("basic_empty_drop",  64'(issue_valid), 64'd0);

    // Wakeup
    busy_bits[9] = 1'b1;
    ins(mk(32'd1, 6'd9, 6'd6));
    tick();
    chk("wake_wait_busy", 64'(issue_valid), 64'd0);
    wb(6'd9);
    chk("wake_not_same_edge", 64'(issue_valid), 64'd0);
    tick();
    chk("wake_issue_valid", 64'(issue_valid), 64'd1);
    chk("wake_issue_count", 64'(issue_entry.count), 64'd1);
    tick();
    busy_bits = '0;

    // Age order: both wait on p20, woken together
    busy_bits[20] = 1'b1;
    ins(mk(32'd10, 6'd20, 6'd6));
    ins(mk(32'd7, 6'd20, 6'd6));
    chk("age_occ", 64'(occupancy), 64'd2);
    wb(6'd20);
    tick();
    chk("age_first",  64'(issue_entry.count), 64'd7);
    tick();
    chk("age_second", 64'(issue_entry.count), 64'd10);
    tick();
    chk("age_drained", 64'(issue_valid), 64'd0);

    // Wrap-around: lower slot holds tag 1, but FFFFFFFF is older
    ins(mk(32'h0000_0001, 6'd20, 6'd6));
    ins(mk(32'hFFFF_FFFF, 6'd20, 6'd6));
    wb(6'd20);
    tick();
    chk("wrap_first",  64'(issue_entry.count), 64'hFFFF_FFFF);
    tick();
    chk("wrap_second", 64'(issue_entry.count), 64'h1);
    tick();
    busy_bits = '0;

    // Full and backpressure
    issue_ready = 1'b0;
    busy_bits[30] = 1'b1;
    for (int i = 0; i < 16; i++) ins(mk(32'(100 + i), 6'd30, 6'd6));
    chk("full_occ",      64'(occupancy), 64'd16);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    ins(mk(32'd200, 6'd5, 6'd6));
    chk("full_drop_occ", 64'(occupancy), 64'd16);
    wb(6'd30);
    tick();
    chk("stall_load_count", 64'(issue_entry.count), 64'd100);
    chk("stall_occ",        64'(occupancy), 64'd15);
    ins(mk(32'd150, 6'd5, 6'd6));
    chk("stall_hold_valid", 64'(issue_valid), 64'd1);
    chk("stall_hold_count", 64'(issue_entry.count), 64'd100);
    chk("stall_accept_occ", 64'(occupancy), 64'd16);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_occ",   64'(occupancy), 64'd0);
    chk("midrst_issue", 64'(issue_valid), 64'd0);
    busy_bits = '0;

    // Flush: tag 24 parked in issue register, 20..23,25 waiting on p40
    busy_bits[40] = 1'b1;
    ins(mk(32'd24, 6'd5, 6'd6));
    ins(mk(32'd20, 6'd40, 6'd6));
    ins(mk(32'd21, 6'd40, 6'd6));
    ins(mk(32'd22, 6'd40, 6'd6));
    ins(mk(32'd23, 6'd40, 6'd6));
    ins(mk(32'd25, 6'd40, 6'd6));
    chk("flush_pre_occ",   64'(occupancy), 64'd5);
    chk("flush_pre_issue", 64'(issue_entry.count), 64'd24);
    flush = 1'b1; flush_tag = 32'd22;
    ins(mk(32'd26, 6'd5, 6'd6));
    flush = 1'b0;
    chk("flush_occ",         64'(occupancy), 64'd3);
    chk("flush_issue_clear", 64'(issue_valid), 64'd0);
    issue_ready = 1'b1;
    wb(6'd40);
    tick();
    chk("flush_surv_0", 64'(issue_entry.count), 64'd20);
    tick();
    chk("flush_surv_1", 64'(issue_entry.count), 64'd21);
    tick();
    chk("flush_surv_2", 64'(issue_entry.count), 64'd22);
    tick();
    chk("flush_end_valid", 64'(issue_valid), 64'd0);
    chk("flush_end_occ",   64'(occupancy), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/instr_issue_queue.md
# instr_issue_queue

Holds renamed instructions produced by the register renaming stage until their source physical registers are ready. Each cycle it selects the oldest ready entry and sends it to the register-read/ALU stage. It also watches writeback broadcasts to wake up waiting operands, and squashes wrong-path entries on a branch mispredict flush. It sits between `register_renaming` and the execute path.

## Interface
- `DEPTH`, 16: number of queue entries (power of two).
- `NUM_PHYS_REGS`, 64: physical register count.
- `PREG_W`, 6: physical register index width.
- `TAG_W`, 32: width of the instruction age tag (`count` field).

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  upstream `instr_wr`: `in_entry` is presented for insertion.
- `in_entry`  in  `Instr_Queue_Entry_t`  renamed instruction.
- `in_ready`  out  1  queue can accept an entry this cycle.
- `busy_bits`  in  `NUM_PHYS_REGS`  busy table; 1 = value not yet written back.
- `wb_valid`  in  1  writeback broadcast valid.
- `wb_preg`  in  `PREG_W`  physical register written back.
- `flush`  in  1  mispredict recovery.
- `flush_tag`  in  `TAG_W`  age tag of the mispredicted branch.
- `issue_valid`  out  1  `issue_entry` holds an issued instruction.
- `issue_entry`  out  `Instr_Queue_Entry_t`  issued instruction.
- `issue_ready`  in  1  downstream accepts `issue_entry` this cycle.
- `occupancy`  out  `$clog2(DEPTH)+1`  number of valid entries in the array (excludes the issue register).

## Operation
- Per-entry state: `valid`, `rs_rdy`, `rt_rdy`, plus the stored `Instr_Queue_Entry_t`.
- **Insert**
  - Occurs when `in_valid & in_ready & !flush`.
  - The entry goes into the lowest-index free slot.
  - Source readiness at insert: `src_rdy = !uses_src | !busy_bits[src_phys] | (wb_valid & wb_preg == src_phys)`.
  - The incoming `in_entry.ready` field is ignored.
- **Wakeup:** when `wb_valid`, every valid entry whose `rs_phys` or `rt_phys` equals `wb_preg` sets the matching `rdy` bit.
- **Select**
  - Candidates are valid entries with both `rdy` bits set.
  - The winner is the candidate with the oldest tag.
  - Age compare is wrap-safe: a is older than b when `$signed(a.count - b.count) < 0`.
- **Issue register**
  - Loads when `!issue_valid | issue_ready`.
  - Loads the winner if one exists; otherwise `issue_valid` goes to 0.
  - The winner's slot is freed on the same edge.
- **Flush**
  - Younger entries are those with `$signed(count - flush_tag) > 0`.
  - On the flush edge, clear `valid` on every younger array entry, and clear `issue_valid` if the issue register holds a younger entry.
  - Selection is suppressed that edge; any `in_valid` that cycle is dropped.
  - Entries with tag ≤ `flush_tag` are retained.
- `in_ready = (occupancy < DEPTH)`. It is based on current occupancy only; a slot freed on the same edge is not counted.

## Timing
- Reset values: every `valid` = 0; `issue_valid` = 0; `issue_entry` = 0; `occupancy` = 0; `in_ready` = 1.
- Minimum latency: an entry inserted at edge E with ready sources has `issue_valid` = 1 after edge E+1.
- Wakeup at edge W: the woken entry can be issued at edge W+1.
- Insert of a source matching the same-cycle `wb_preg` is treated as ready (bypass).
- Stall: while `issue_valid & !issue_ready`, the issue register holds and the array keeps accepting and waking.
- Full (`occupancy == DEPTH`): `in_ready` = 0; any `in_valid` is ignored.
- Empty: `issue_valid` falls after the outstanding entry is accepted.
- Flush has priority over insert and select; wakeup still applies to surviving entries that edge.
- `rst` mid-operation: all state is cleared on that edge regardless of other inputs.

## Structure
- Move `Instr_Queue_Entry_t` and the `DEPTH`/`PREG_W`/`TAG_W` constants into `mips_core_pkg`, so `register_renaming` and this block share one definition.
- Sub-module `iq_age_select`: combinational oldest-ready picker, taking per-entry request and tag vectors and returning a one-hot grant plus a `found` flag.

## Test plan
- **Basic issue:** insert rs=5, rt=6 with busy all 0 at cycle 0, `issue_ready`=1 → `issue_valid`=1 after edge 1 with `count`=0; `occupancy` returns to 0.
- **Wakeup:** insert with busy[9]=1 (rs=9), then `wb_valid`, `wb_preg`=9 at cycle 3 → issue after edge 4, not before.
- **Age order:** insert tags 10 then 7, both ready → tag 7 issues first, tag 10 next.
- **Wrap-around:** tags 0xFFFFFFFF and 0x00000001, both ready → 0xFFFFFFFF issues first.
- **Full/backpressure:** fill 16 entries with `issue_ready`=0 → `in_ready`=0 and a 17th insert is dropped; `occupancy`=16.
- **Flush:** entries with tags 20–25, `flush` with `flush_tag`=22 → tags 23–25 removed, `occupancy`=3, same-cycle insert dropped; a tag 24 held in the issue register is also cleared.
